// File: rtl/rsd_pkg.sv
// Shared definitions for the repeated-subtraction divider: default operand
// width and the controller state encoding.
package rsd_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        SUB    = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/rsd_controller.sv
// Control FSM for the repeated-subtraction divider. It issues load, subtract
// and counter strobes to the datapath and decodes busy/done from the state.
module rsd_controller
    import rsd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic a_ge_b,
    input  logic b_zero,
    output logic ld_a,
    output logic ld_b,
    output logic sub_en,
    output logic clr_cnt,
    output logic inc_cnt,
    output logic set_dbz,
    output logic busy,
    output logic done
);

    state_e state_q;
    state_e state_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output gets a default before the case statement; a missing
    // assignment on any path would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        sub_en  = 1'b0;
        clr_cnt = 1'b0;
        inc_cnt = 1'b0;
        set_dbz = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ld_a    = 1'b1;
                    clr_cnt = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                busy    = 1'b1;
                ld_b    = 1'b1;
                state_d = SUB;
            end
            SUB: begin
                busy = 1'b1;
                // Divide-by-zero is tested first so a zero divisor never loops.
                if (b_zero) begin
                    set_dbz = 1'b1;
                    state_d = DONE;
                end else if (a_ge_b) begin
                    sub_en  = 1'b1;
                    inc_cnt = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    ld_a    = 1'b1;
                    clr_cnt = 1'b1;
                    state_d = LOAD_B;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/repeated_subtraction_divider.sv
// Unsigned divider by repeated subtraction: dividend then divisor arrive on
// data_in in consecutive cycles; one subtract and one quotient increment per clock.
module repeated_subtraction_divider
    import rsd_pkg::*;
#(
    parameter int WIDTH = rsd_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic ld_a, ld_b, sub_en, clr_cnt, inc_cnt, set_dbz;
    logic a_ge_b, b_zero;

    assign a_ge_b = (a_q >= b_q);
    assign b_zero = (b_q == '0);

    rsd_controller u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_ge_b  (a_ge_b),
        .b_zero  (b_zero),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .sub_en  (sub_en),
        .clr_cnt (clr_cnt),
        .inc_cnt (inc_cnt),
        .set_dbz (set_dbz),
        .busy    (busy),
        .done    (done)
    );

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        dbz_d = dbz_q;

        if (ld_a)    a_d = data_in;
        if (ld_b)    b_d = data_in;
        // Only issued when A >= B, so the subtraction cannot underflow.
        if (sub_en)  a_d = a_q - b_q;
        if (clr_cnt) begin
            cnt_d = '0;
            dbz_d = 1'b0;
        end
        if (inc_cnt) cnt_d = cnt_q + 1'b1;
        if (set_dbz) begin
            cnt_d = '1;
            dbz_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient    = cnt_q;
    assign remainder   = a_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_repeated_subtraction_divider.sv
// Scoreboard bench for repeated_subtraction_divider: the driver queues the
// hand-computed result of each division, the monitor checks it when done rises.
module tb_repeated_subtraction_divider;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] dividend;
        logic [W-1:0] divisor;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           start_cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t exp_q[$];

    repeated_subtraction_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: one scoreboard entry is consumed per rising edge of done.
    initial begin : monitor
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("quotient", 32'(quotient), 32'(e.q));
                        check("remainder", 32'(remainder), 32'(e.r));
                        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                        check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    end
                end
                done_prev = done;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic run_op(input vec_t v, input bit toggle);
        exp_t e;
        bit   busy_ok;
        e.q = v.q;
        e.r = v.r;
        e.dbz = v.dbz;
        e.lat = v.lat;
        e.start_cyc = cyc + 1;
        exp_q.push_back(e);
        start   = 1'b1;
        data_in = v.dividend;
        @(negedge clk);
        start   = 1'b0;
        data_in = v.divisor;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_drops", 32'(done), 32'd0);
        @(negedge clk);
        data_in = 16'hA5A5;
        busy_ok = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            if (done) break;
            busy_ok &= busy;
            if (toggle) start = (i % 3 == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        check("busy_while_running", 32'(busy_ok), 32'd1);
        check("busy_low_in_done", 32'(busy), 32'd0);
    endtask

    initial begin : driver
        vec_t vecs[8];
        vec_t v;
        vecs[0] = '{dividend: 16'd100,   divisor: 16'd3,  q: 16'd33,    r: 16'd1,  dbz: 1'b0, lat: 35};
        vecs[1] = '{dividend: 16'd7,     divisor: 16'd9,  q: 16'd0,     r: 16'd7,  dbz: 1'b0, lat: 2};
        vecs[2] = '{dividend: 16'd0,     divisor: 16'd5,  q: 16'd0,     r: 16'd0,  dbz: 1'b0, lat: 2};
        vecs[3] = '{dividend: 16'd42,    divisor: 16'd0,  q: 16'hFFFF,  r: 16'd42, dbz: 1'b1, lat: 2};
        vecs[4] = '{dividend: 16'd50,    divisor: 16'd7,  q: 16'd7,     r: 16'd1,  dbz: 1'b0, lat: 9};
        vecs[5] = '{dividend: 16'd65535, divisor: 16'd1,  q: 16'd65535, r: 16'd0,  dbz: 1'b0, lat: 65537};
        vecs[6] = '{dividend: 16'd12,    divisor: 16'd12, q: 16'd1,     r: 16'd0,  dbz: 1'b0, lat: 3};
        vecs[7] = '{dividend: 16'd100,   divisor: 16'd3,  q: 16'd33,    r: 16'd1,  dbz: 1'b0, lat: 35};

        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // First op starts from IDLE, the rest restart directly from DONE.
        for (int i = 0; i < 7; i++) run_op(vecs[i], 1'b0);
        run_op(vecs[7], 1'b1);

        // Abort 100 / 3 with an asynchronous reset in the middle of SUB.
        start   = 1'b1;
        data_in = 16'd100;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd3;
        repeat (10) @(negedge clk);
        check("mid_sub_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_abort", 32'({busy, done}), 32'd0);

        v = '{dividend: 16'd9, divisor: 16'd2, q: 16'd4, r: 16'd1, dbz: 1'b0, lat: 6};
        run_op(v, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("done_held", 32'(done), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
